// File: rtl/polytop_op_seq.sv
// polytop_op_seq: descriptor FIFO and sequencer driving polytop_RE.
// Runs gap/start/wait/dump per command with a per-operation watchdog.
module polytop_op_seq #(
  parameter int DEPTH      = 8,
  parameter int GAP_W      = 8,
  parameter int TIMEOUT_W  = 16,
  parameter int BANK_ROW   = 63,
  parameter int ROW_BASE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_wr_en,
  input  logic [8+GAP_W-1:0]     cmd_wr_data,
  output logic                   cmd_full,
  output logic [$clog2(DEPTH):0] cmd_count,
  input  logic                   run,
  input  logic                   abort,
  output logic                   core_rst,
  output logic [1:0]             core_opcode,
  output logic                   core_mode,
  output logic                   core_offset,
  output logic                   core_start,
  input  logic                   core_finish,
  output logic                   dump_req,
  input  logic                   dump_ack,
  output logic [1:0]             dump_sel,
  output logic [ROW_BASE_W-1:0]  dump_row_base,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = 8 + GAP_W;
  localparam int CNTW = AW + 1;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_TWO = GAP_W'(2);
  localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [ROW_BASE_W-1:0] ROW_HI =
    ROW_BASE_W'(BANK_ROW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_START, S_WAIT, S_DUMP, S_NEXT
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]         count_q, count_d;
  logic                    full_q;
  logic                    first_q;
  logic [GAP_W-1:0]        gap_cnt_q;
  logic [TIMEOUT_W-1:0]    wd_q;
  logic                    den_q, dhi_q;
  logic [1:0]              dsel_q;
  logic [1:0]              op_q;
  logic                    mode_q, off_q;
  logic                    core_rst_q, start_q;
  logic                    dreq_q;
  logic [1:0]              dump_sel_q;
  logic [ROW_BASE_W-1:0]   row_base_q;
  logic                    busy_q, done_q, err_q;

  logic                    timeout, flush, push, pop;
  logic [CW-1:0]           head;
  logic [GAP_W-1:0]        head_gap;

  assign head     = mem_q[rd_ptr_q];
  assign head_gap = head[CW-1:8];

  assign cmd_full      = full_q;
  assign cmd_count     = count_q;
  assign core_rst      = core_rst_q;
  assign core_opcode   = op_q;
  assign core_mode     = mode_q;
  assign core_offset   = off_q;
  assign core_start    = start_q;
  assign dump_req      = dreq_q;
  assign dump_sel      = dump_sel_q;
  assign dump_row_base = row_base_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // FIFO control: full drops pushes, abort/timeout flush everything
  always_comb begin
    timeout = (state_q == S_WAIT) && !core_finish
              && (wd_q == WD_LAST);
    flush   = abort || timeout;
    push    = cmd_wr_en && !full_q && !flush;
    pop     = (state_q == S_NEXT) && !abort;
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + CNT_ONE;
    else if (pop && !push)  count_d = count_q - CNT_ONE;
  end

  // descriptor storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_MAX);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // sequencer FSM with all core/dump controls registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      gap_cnt_q  <= '0;
      wd_q       <= '0;
      den_q      <= 1'b0;
      dhi_q      <= 1'b0;
      dsel_q     <= 2'd0;
      op_q       <= 2'd0;
      mode_q     <= 1'b0;
      off_q      <= 1'b0;
      core_rst_q <= 1'b1;
      start_q    <= 1'b0;
      dreq_q     <= 1'b0;
      dump_sel_q <= 2'd0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        core_rst_q <= 1'b1;
        dreq_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (run) begin
              err_q <= 1'b0;
              if (count_q != '0) begin
                state_q    <= S_GAP;
                first_q    <= 1'b1;
                core_rst_q <= 1'b1;
                busy_q     <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (first_q) begin
              first_q <= 1'b0;
              op_q    <= head[1:0];
              mode_q  <= head[2];
              off_q   <= head[3];
              den_q   <= head[4];
              dsel_q  <= head[6:5];
              dhi_q   <= head[7];
              if (head_gap <= GAP_ONE) begin
                state_q    <= S_START;
                core_rst_q <= 1'b0;
                start_q    <= 1'b1;
              end else begin
                gap_cnt_q <= head_gap - GAP_TWO;
              end
            end else if (gap_cnt_q == '0) begin
              state_q    <= S_START;
              core_rst_q <= 1'b0;
              start_q    <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q - GAP_ONE;
            end
          end
          S_START: begin
            state_q <= S_WAIT;
            wd_q    <= '0;
          end
          S_WAIT: begin
            if (core_finish) begin
              if (den_q) begin
                state_q    <= S_DUMP;
                dreq_q     <= 1'b1;
                dump_sel_q <= dsel_q;
                row_base_q <= dhi_q ? ROW_HI : '0;
              end else begin
                state_q <= S_NEXT;
              end
            end else if (wd_q == WD_LAST) begin
              state_q    <= S_IDLE;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              core_rst_q <= 1'b1;
            end else begin
              wd_q <= wd_q + WD_ONE;
            end
          end
          S_DUMP: begin
            if (dump_ack) begin
              dreq_q  <= 1'b0;
              state_q <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (count_d != '0) begin
              state_q    <= S_GAP;
              first_q    <= 1'b1;
              core_rst_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_polytop_op_seq.sv
// tb_polytop_op_seq: directed bench for the op sequencer.
// Core and dump-agent models run alongside one linear stimulus block.
module tb_polytop_op_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_wr_en = 1'b0;
  logic [15:0] cmd_wr_data = '0;
  logic        cmd_full;
  logic [3:0]  cmd_count;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        core_rst;
  logic [1:0]  core_opcode;
  logic        core_mode, core_offset, core_start;
  logic        core_finish = 1'b0;
  logic        dump_req;
  logic        dump_ack = 1'b0;
  logic [1:0]  dump_sel;
  logic [7:0]  dump_row_base;
  logic        busy, done, err;

  logic hang = 1'b0;
  logic hold_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  polytop_op_seq #(
    .DEPTH(8), .GAP_W(8), .TIMEOUT_W(6),
    .BANK_ROW(63), .ROW_BASE_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .cmd_full(cmd_full), .cmd_count(cmd_count),
    .run(run), .abort(abort),
    .core_rst(core_rst), .core_opcode(core_opcode),
    .core_mode(core_mode), .core_offset(core_offset),
    .core_start(core_start), .core_finish(core_finish),
    .dump_req(dump_req), .dump_ack(dump_ack),
    .dump_sel(dump_sel), .dump_row_base(dump_row_base),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // core model: finish 50 cycles after start unless hung
  int fin_cnt = 0;
  always @(posedge clk) begin
    core_finish <= 1'b0;
    if (core_rst) fin_cnt <= 0;
    else if (core_start) fin_cnt <= hang ? 0 : 50;
    else if (fin_cnt != 0) begin
      fin_cnt <= fin_cnt - 1;
      if (fin_cnt == 1) core_finish <= 1'b1;
    end
  end

  // dump agent: ack two cycles into a request, log target
  int n_dump = 0;
  int ack_dly = 0;
  logic [1:0] dsel_log [64];
  logic [7:0] dbase_log [64];
  always @(posedge clk) begin
    dump_ack <= 1'b0;
    if (dump_req && !dump_ack && !hold_ack) begin
      if (ack_dly == 2) begin
        dump_ack <= 1'b1;
        ack_dly  <= 0;
        dsel_log[n_dump[5:0]]  <= dump_sel;
        dbase_log[n_dump[5:0]] <= dump_row_base;
        n_dump <= n_dump + 1;
      end else begin
        ack_dly <= ack_dly + 1;
      end
    end
  end

  // monitors: starts, done pulses, reset run length, dump stability
  int n_start = 0;
  int n_done = 0;
  int rst_run = 0;
  int last_gap = 0;
  int unstable = 0;
  logic [3:0] op_log [64];
  logic       prev_req = 1'b0;
  logic [1:0] prev_sel = '0;
  logic [7:0] prev_base = '0;
  always @(posedge clk) begin
    if (core_start) begin
      op_log[n_start[5:0]] <=
        {core_opcode, core_mode, core_offset};
      n_start  <= n_start + 1;
      last_gap <= rst_run;
    end
    rst_run <= core_rst ? rst_run + 1 : 0;
    if (done) n_done <= n_done + 1;
    if (dump_req && prev_req &&
        (dump_sel !== prev_sel ||
         dump_row_base !== prev_base))
      unstable <= unstable + 1;
    prev_req  <= dump_req;
    prev_sel  <= dump_sel;
    prev_base <= dump_row_base;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(
    input logic [1:0] op, input logic m, input logic o,
    input logic de, input logic [1:0] ds,
    input logic hi, input logic [7:0] g);
    return {g, hi, ds, de, o, m, op};
  endfunction

  task automatic push(input logic [15:0] d);
    cmd_wr_en   = 1'b1;
    cmd_wr_data = d;
    tick();
    cmd_wr_en   = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k = 0;
    while (core_start !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, core_start, 1);
  endtask

  task automatic wait_dreq(input string tag, input int budget);
    int k = 0;
    while (dump_req !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, dump_req, 1);
  endtask

  task automatic wait_room(input string tag, input int budget);
    int k = 0;
    while (cmd_full !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, cmd_full, 0);
  endtask

  initial begin
    int s0, d0, p0;
    logic [3:0] exp_chain [5];
    logic [1:0] exp_sel [4];
    logic [7:0] exp_base [4];
    logic [3:0] t;

    exp_chain = '{4'd0, 4'd3, 4'd8, 4'd12, 4'd4};
    exp_sel   = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_base  = '{8'd0, 8'd64, 8'd0, 8'd0};

    // reset values
    repeat (3) tick();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_full", cmd_full, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_dreq", dump_req, 0);
    chk("rst_base", dump_row_base, 0);
    rst = 1'b1;
    tick();

    // five-command chain
    s0 = n_start; d0 = n_done; p0 = n_dump;
    push(mk(2'd0, 0, 0, 1, 2'd0, 0, 8'd2));
    push(mk(2'd0, 1, 1, 1, 2'd1, 1, 8'd2));
    push(mk(2'd2, 0, 0, 0, 2'd0, 0, 8'd1));
    push(mk(2'd3, 0, 0, 1, 2'd2, 0, 8'd1));
    push(mk(2'd1, 0, 0, 1, 2'd3, 0, 8'd1));
    chk("chain_count", cmd_count, 5);
    pulse_run();
    chk("chain_busy", busy, 1);
    wait_done("chain_done", 1500);
    chk("chain_busy_fall", busy, 0);
    chk("chain_core_rst_low", core_rst, 0);
    chk("chain_err", err, 0);
    tick();
    chk("chain_ndone", n_done - d0, 1);
    chk("chain_nstart", n_start - s0, 5);
    chk("chain_ndump", n_dump - p0, 4);
    for (int k = 0; k < 5; k++)
      chk("chain_op", op_log[s0 + k], exp_chain[k]);
    for (int k = 0; k < 4; k++) begin
      chk("chain_dsel", dsel_log[p0 + k], exp_sel[k]);
      chk("chain_dbase", dbase_log[p0 + k], exp_base[k]);
    end
    chk("dump_stable", unstable, 0);

    // reset gap lengths
    push(mk(2'd0, 0, 0, 0, 2'd0, 0, 8'd0));
    pulse_run();
    wait_done("gap0_done", 300);
    chk("gap0_len", last_gap, 1);
    push(mk(2'd0, 0, 0, 0, 2'd0, 0, 8'd5));
    pulse_run();
    wait_done("gap5_done", 300);
    chk("gap5_len", last_gap, 5);

    // overflow, append during run, wrap ordering
    s0 = n_start;
    for (int k = 0; k < 9; k++) begin
      t = 4'(k & 7);
      push(mk(t[1:0], t[2], t[3], 0, 2'd0, 0, 8'd1));
    end
    chk("ovf_full", cmd_full, 1);
    chk("ovf_count", cmd_count, 8);
    pulse_run();
    for (int j = 0; j < 3; j++) begin
      wait_room("app_room", 300);
      t = 4'(9 + j);
      push(mk(t[1:0], t[2], t[3], 0, 2'd0, 0, 8'd1));
    end
    wait_done("wrap_done", 2000);
    tick();
    chk("wrap_nstart", n_start - s0, 11);
    for (int k = 0; k < 11; k++) begin
      t = (k < 8) ? 4'(k) : 4'(k + 1);
      chk("wrap_op", op_log[s0 + k],
          {28'd0, t[1:0], t[2], t[3]});
    end

    // watchdog timeout
    hang = 1'b1;
    d0 = n_done;
    push(mk(2'd1, 0, 0, 0, 2'd0, 0, 8'd1));
    push(mk(2'd2, 0, 0, 0, 2'd0, 0, 8'd1));
    pulse_run();
    wait_start("to_start", 100);
    repeat (63) tick();
    chk("to_err_early", err, 0);
    chk("to_busy_early", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_count", cmd_count, 0);
    chk("to_busy", busy, 0);
    repeat (3) tick();
    chk("to_nodone", n_done - d0, 0);
    hang = 1'b0;

    // empty run: done next cycle, clears err, core untouched
    s0 = n_start;
    pulse_run();
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_err_clr", err, 0);
    tick();
    chk("empty_done_pulse", done, 0);
    chk("empty_nostart", n_start - s0, 0);

    // abort mid-WAIT
    d0 = n_done;
    push(mk(2'd0, 0, 0, 1, 2'd1, 0, 8'd1));
    push(mk(2'd0, 0, 0, 1, 2'd1, 0, 8'd1));
    pulse_run();
    wait_start("abw_start", 100);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abw_busy", busy, 0);
    chk("abw_core_rst", core_rst, 1);
    chk("abw_dreq", dump_req, 0);
    chk("abw_count", cmd_count, 0);

    // abort mid-DUMP
    hold_ack = 1'b1;
    push(mk(2'd3, 0, 0, 1, 2'd2, 0, 8'd1));
    push(mk(2'd3, 0, 0, 1, 2'd2, 0, 8'd1));
    pulse_run();
    wait_dreq("abd_dreq", 200);
    repeat (3) tick();
    chk("abd_dreq_hold", dump_req, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abd_busy", busy, 0);
    chk("abd_core_rst", core_rst, 1);
    chk("abd_dreq", dump_req, 0);
    chk("abd_count", cmd_count, 0);
    repeat (3) tick();
    chk("ab_nodone", n_done - d0, 0);

    // asynchronous reset mid-DUMP
    push(mk(2'd1, 1, 1, 1, 2'd3, 1, 8'd1));
    pulse_run();
    wait_dreq("ar_dreq", 200);
    chk("ar_sel_pre", dump_sel, 3);
    chk("ar_base_pre", dump_row_base, 64);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_core_rst", core_rst, 1);
    chk("ar_busy", busy, 0);
    chk("ar_dreq", dump_req, 0);
    chk("ar_sel", dump_sel, 0);
    chk("ar_base", dump_row_base, 0);
    chk("ar_op", core_opcode, 0);
    chk("ar_mode", core_mode, 0);
    chk("ar_count", cmd_count, 0);
    hold_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/polytop_op_seq.md
# polytop_op_seq

Parametrised command sequencer placed in front of `polytop_RE`. It replaces hand-written per-operation start/finish/reset sequencing with a FIFO of operation descriptors covering opcode, mode, offset, reset gap and an optional dump request. It executes the descriptors back to back, drives the core's reset, start and operation controls, and hands each finished result to a bank-dump agent over a req/ack handshake. A watchdog guards every core operation.

## Interface
Parameters:
- `DEPTH`, default 8: command FIFO slots; power of two, ≥2.
- `GAP_W`, default 8: width of the per-command reset-gap field.
- `TIMEOUT_W`, default 16: width of the watchdog counter.
- `BANK_ROW`, default 63: last row index of one polynomial half in a bank.
- `ROW_BASE_W`, default 8: width of `dump_row_base`; must hold `BANK_ROW+1`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_wr_en`  in  1  push `cmd_wr_data`.
- `cmd_wr_data`  in  8+GAP_W  field layout:
  - [1:0] opcode (00 NTT, 01 INTT, 10 PWM0, 11 PWM1)
  - [2] mode, [3] offset
  - [4] dump_en, [6:5] dump_sel (0 F, 1 G, 2 HAT, 3 H)
  - [7] dump_hi
  - [8+GAP_W-1:8] gap
- `cmd_full`  out  1  FIFO full.
- `cmd_count`  out  $clog2(DEPTH)+1  entries held.
- `run`  in  1  pulse; begin executing the FIFO.
- `abort`  in  1  pulse; flush and stop.
- `core_rst`  out  1  active-high reset to the core.
- `core_opcode`  out  2, `core_mode`  out  1, `core_offset`  out  1: operation controls.
- `core_start`  out  1  one-cycle start pulse.
- `core_finish`  in  1  finish pulse from the core.
- `dump_req`  out  1, `dump_ack`  in  1: dump handshake.
- `dump_sel`  out  2, `dump_row_base`  out  ROW_BASE_W: dump target.
- `busy`  out  1, `done`  out  1 (pulse), `err`  out  1 (sticky timeout).

## Operation
- States: IDLE, GAP, START, WAIT, DUMP, NEXT.
- IDLE → GAP on `run` when FIFO is non-empty. On `run` with an empty FIFO, `done` pulses next cycle and the core is not touched. `run` outside IDLE is ignored.
- GAP:
  - `core_rst`=1 for max(gap,1) cycles.
  - `core_opcode`/`core_mode`/`core_offset` load from the FIFO head on the first GAP cycle and hold until the next GAP entry.
- START: `core_rst`=0, `core_start`=1 for exactly one cycle, then WAIT.
- WAIT:
  - Watchdog clears on entry and increments each cycle.
  - `core_finish` → DUMP if dump_en, else NEXT.
  - Watchdog reaching 2^TIMEOUT_W−1 → `err`=1, FIFO flushed, IDLE, no `done`.
- DUMP:
  - `dump_req`=1 until `dump_ack` is sampled high, then NEXT.
  - `dump_sel` comes from the command.
  - `dump_row_base` = BANK_ROW+1 if dump_hi, else 0.
  - Both are stable while `dump_req`=1.
- NEXT: pop the head. Go to GAP if the FIFO is still non-empty; otherwise go to IDLE with a `done` pulse.
- FIFO:
  - Pushes are accepted in every state, including during a run. Appended commands execute in the same run.
  - A push while `cmd_full` is dropped, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full: `cmd_count` unchanged.
- `abort` has priority over everything. In any state, the next cycle is IDLE, the FIFO is flushed, `core_start`=0, `dump_req`=0, `core_rst`=1, and there is no `done` pulse.
- `err` clears only on an accepted `run`.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values:
  - `core_rst`=1.
  - `core_start`, `core_opcode`, `core_mode`, `core_offset`, `dump_req`, `dump_sel`, `dump_row_base` = 0.
  - `busy`, `done`, `err`, `cmd_full`, `cmd_count` = 0.
- After a completed run, `core_rst` stays 0 in IDLE so the core contents remain readable.
- `run` sampled at cycle t → GAP at t+1. With gap=g, `core_start` is at t+1+max(g,1).
- `core_finish` is not sampled in START; a finish coincident with `core_start` is ignored.
- Per-command overhead excluding core latency: max(g,1) + 1 (START) + 1 (NEXT) + dump cycles. The dump phase takes ≥1 cycle, and `dump_ack` is combinationally allowed.
- `done` and `busy` falling occur in the same cycle, one cycle after the final NEXT.
- All outputs are registered.

## Test plan
- Push the five-command chain:
  - NTT (mode0, offset0, dump F, lo, gap 2)
  - NTT (mode1, offset1, dump G, hi, gap 2)
  - PWM0 (no dump)
  - PWM1 (dump HAT, lo)
  - INTT (dump H, lo)

  Then `run`, with a core model whose finish arrives 50 cycles after start. Required: five `core_start` pulses; four dump requests with (sel,row_base) = (0,0), (1,64), (2,0), (3,0); one `done`; `err`=0.
- gap=0 versus gap=5: `core_rst` is high for exactly 1 and 5 cycles respectively before `core_start`.
- Push 9 commands with DEPTH=8: the ninth is dropped, `cmd_full`=1, `cmd_count`=8. Then `run`, and push during execution: the appended commands execute; the wrap-around ordering is preserved.
- Core model never finishes, with TIMEOUT_W=6: `err` rises after 63 WAIT cycles, `cmd_count`=0, no `done`. The next `run` clears `err`.
- `abort` asserted mid-WAIT and mid-DUMP: IDLE next cycle, `core_rst`=1, `dump_req`=0, FIFO empty. `rst` asserted low mid-run: all outputs return to reset values immediately.
- `run` with an empty FIFO: `done` one cycle later, `busy` stays 0, `core_start` is never asserted.
